rr_arbiter4: RTL

Four-requester round-robin arbiter that owns the one-hot grant lines for a shared resource. It emits both a 2-bit grant index and the one-hot grant vector. The one-hot vector uses the team's 2-to-4 decoding: index 0 maps to 4'b0001 and index 3 maps to 4'b1000. The block sits between up to four requesting agents and the resource select, so at most one agent drives the resource per cycle. A hold limit keeps a long-running owner from starving the others.

---
 rtl/rr_arbiter4.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with a hold limit.
// Drives a registered grant index, its one-hot decode, a valid flag and a
// one-cycle preempt pulse. All outputs are flops, so there is no
// combinational path from req to any output.
`timescale 1ns/1ps

module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8,  // max consecutive cycles while others wait (1..255)
  parameter int unsigned CNT_W    = 8   // hold counter width, 2**CNT_W > MAX_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       preempt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Last cycle an owner may keep the resource while someone else is waiting.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n;
  logic [CNT_W-1:0] hold_cnt, hold_n;
  logic [1:0]       idx_n;
  logic             valid_n;
  logic             preempt_n;
  logic [3:0]       grant_n;

  // Circular priority scan: candidates start, start+1, start+2, start+3
  // (mod 4); the first set request wins. Returns {found, winner}.
  function automatic logic [2:0] scan(input logic [3:0] r, input logic [1:0] start);
    logic       found;
    logic [1:0] win;
    logic [1:0] cand;
    found = 1'b0;
    win   = start;
    for (int k = 0; k < 4; k++) begin
      cand = start + 2'(k);
      if (!found && r[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    return {found, win};
  endfunction

  logic       owner_req;
  logic [3:0] others;
  logic       rr_found;
  logic [1:0] rr_win;
  logic       pre_found;
  logic [1:0] pre_win;

  // Current owner's request and everyone else's; the preempt search starts
  // just past the owner and only looks at the others, so the owner cannot win.
  assign owner_req              = req[grant_idx];
  assign others                 = req & ~(4'b0001 << grant_idx);
  assign {rr_found, rr_win}     = scan(req, ptr);
  assign {pre_found, pre_win}   = scan(others, grant_idx + 2'd1);

  // Next-state and next-output decision for the arbitration FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case/if tree leaves one unassigned and infers a latch.
    state_n   = state;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    idx_n     = grant_idx;
    valid_n   = grant_valid;
    preempt_n = 1'b0;

    case (state)
      IDLE: begin
        if (rr_found) begin
          state_n = BUSY;
          valid_n = 1'b1;
          idx_n   = rr_win;
          ptr_n   = rr_win + 2'd1;
          hold_n  = '0;
        end
      end

      BUSY: begin
        if (!owner_req) begin
          // Release takes precedence over any pending preemption.
          if (rr_found) begin
            idx_n  = rr_win;
            ptr_n  = rr_win + 2'd1;
            hold_n = '0;
          end else begin
            state_n = IDLE;
            valid_n = 1'b0;
            hold_n  = '0;
          end
        end else if (hold_cnt == HOLD_LAST && pre_found) begin
          // Hold limit reached with someone waiting: hand over and flag it.
          idx_n     = pre_win;
          ptr_n     = pre_win + 2'd1;
          hold_n    = '0;
          preempt_n = 1'b1;
        end else if (hold_cnt != HOLD_LAST) begin
          // Saturating count, so a sole requester keeps its grant forever.
          hold_n = hold_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase

    grant_n = valid_n ? (4'b0001 << idx_n) : 4'b0000;
  end

  // State, pointer, counter and output registers with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      hold_cnt    <= '0;
      grant_idx   <= 2'd0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
      grant       <= 4'b0000;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state       <= state_n;
      ptr         <= ptr_n;
      hold_cnt    <= hold_n;
      grant_idx   <= idx_n;
      grant_valid <= valid_n;
      preempt     <= preempt_n;
      grant       <= grant_n;
    end
  end

endmodule
